// File: rtl/bcd_countdown_timer_pkg.sv
// timer_pkg: shared constants and helpers for the BCD countdown timer.
//   BCD_W                    width of one BCD digit
//   ST_IDLE/RUN/PAUSE/END    FSM state encoding
//   digit_max(idx)           largest value digit idx may hold
// Optional macro TIMER_MMSS_EN: digits 1 and 3 top out at 5 (mm:ss format).
package timer_pkg;
    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    function automatic logic [BCD_W-1:0] digit_max(input int idx);
`ifdef TIMER_MMSS_EN
        return (idx == 1 || idx == 3) ? 4'd5 : 4'd9;
`else
        return 4'd9;
`endif
    endfunction
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: command/status bundle of the BCD timer.
//   master: drives CE, START, STOP, LOAD, LOAD_VAL, UP; reads Q, RUN, DONE
//   slave : the timer core
interface bcd_countdown_timer_if #(parameter int DIGITS = 4);
    logic                  CE;
    logic                  START;
    logic                  STOP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic                  UP;
    logic [4*DIGITS-1:0]   Q;
    logic                  RUN;
    logic                  DONE;

    modport master (output CE, START, STOP, LOAD, LOAD_VAL, UP,
                    input  Q, RUN, DONE);
    modport slave  (input  CE, START, STOP, LOAD, LOAD_VAL, UP,
                    output Q, RUN, DONE);
endinterface

// File: rtl/bcd_countdown_timer_bcd_digit_cnt.sv
// bcd_digit_cnt: one registered BCD digit of the ripple counter.
//   i_clk, i_rst_n  clock, async active-low reset (digit -> 0)
//   i_load          load i_load_val, clamped to MAX
//   i_en            commit o_nxt into the register
//   i_up            step direction (1 = up)
//   i_cin           carry/borrow in: this digit steps when set
//   o_q             current digit
//   o_nxt           digit value after a step (o_q when i_cin is low)
//   o_cout          carry/borrow out: this digit steps and wraps
// Optional macro TIMER_MMSS_EN affects MAX via timer_pkg::digit_max.
module bcd_digit_cnt
    import timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_q,
    output logic [BCD_W-1:0] o_nxt,
    output logic             o_cout
);
    logic [BCD_W-1:0] r_q;
    logic             w_at_lim;
    logic [BCD_W-1:0] w_step;

    assign w_at_lim = i_up ? (r_q == MAX) : (r_q == '0);

    always_comb begin
        w_step = r_q;
        if (i_up) w_step = w_at_lim ? '0 : r_q + 4'd1;
        else      w_step = w_at_lim ? MAX : r_q - 4'd1;
    end

    assign o_nxt  = i_cin ? w_step : r_q;
    assign o_cout = i_cin & w_at_lim;
    assign o_q    = r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= '0;
        else if (i_load)
            r_q <= (i_load_val > MAX) ? MAX : i_load_val;
        else if (i_en)
            r_q <= o_nxt;
    end
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: BCD up/down timer with preset, start/stop/load and
// a one-cycle DONE pulse on reaching the terminal value.
//   CLK   system clock
//   CLR   async active-low reset
//   bus   bcd_countdown_timer_if.slave (commands in, Q/RUN/DONE out)
// Optional macro TIMER_MMSS_EN: mm:ss digit maxima (needs DIGITS >= 2).
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    bcd_countdown_timer_if.slave  bus
);
    localparam int W = BCD_W * DIGITS;

    logic [1:0]    r_state;
    logic [W-1:0]  r_preset;
    logic          r_done;

    logic [W-1:0]  w_q, w_nxt, w_max, w_term, w_load_val;
    logic [DIGITS:0] w_carry;
    logic          w_at_term, w_start_end, w_load, w_tick, w_step, w_hit;

    // The chain is always fed a carry-in of 1, so the ripple out of the top
    // digit says "every digit is at its limit", i.e. Q is already terminal.
    // The register only commits when w_step is set.
    assign w_carry[0] = 1'b1;
    assign w_at_term  = w_carry[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            localparam logic [BCD_W-1:0] MX = digit_max(g);
            assign w_max[g*BCD_W +: BCD_W] = MX;
            bcd_digit_cnt #(.MAX(MX)) u_digit (
                .i_clk      (CLK),
                .i_rst_n    (CLR),
                .i_load     (w_load),
                .i_load_val (w_load_val[g*BCD_W +: BCD_W]),
                .i_en       (w_step),
                .i_up       (bus.UP),
                .i_cin      (w_carry[g]),
                .o_q        (w_q[g*BCD_W +: BCD_W]),
                .o_nxt      (w_nxt[g*BCD_W +: BCD_W]),
                .o_cout     (w_carry[g+1])
            );
        end
    endgenerate

    assign w_term      = bus.UP ? w_max : '0;
    assign w_start_end = ~bus.LOAD & bus.START & (r_state == ST_END);
    assign w_load      = bus.LOAD | w_start_end;
    assign w_load_val  = bus.LOAD ? bus.LOAD_VAL : r_preset;

    // A tick survives only in RUN with no LOAD/STOP beside it. If Q is
    // already terminal (direction just flipped) it ends without stepping.
    assign w_tick = ~bus.LOAD & ~bus.STOP & bus.CE & (r_state == ST_RUN);
    assign w_step = w_tick & ~w_at_term;
    assign w_hit  = w_tick & (w_at_term | (w_nxt == w_term));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state  <= ST_IDLE;
            r_preset <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_hit;
            if (bus.LOAD) begin
                r_state  <= ST_IDLE;
                r_preset <= bus.LOAD_VAL;
            end else if (bus.STOP && r_state == ST_RUN) begin
                r_state <= ST_PAUSE;
            end else if (bus.START && r_state != ST_RUN) begin
                if (r_state == ST_END || !w_at_term)
                    r_state <= ST_RUN;
            end else if (w_hit) begin
                r_state <= ST_END;
            end
        end
    end

    assign bus.Q    = w_q;
    assign bus.RUN  = (r_state == ST_RUN);
    assign bus.DONE = r_done;
endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised BCD countdown/count-up timer core for the countdown-timer display path. Counts directly in packed BCD digits, so the binary-to-decimal division stage in the top level is no longer needed. Sits between the debounced button/prescaler enables and the 7-segment driver, whose IN bus it feeds directly. Adds a preset register, start/stop/load commands, a direction mode, a done pulse and an optional mm:ss digit format.

## Interface
- DIGITS, 4: number of BCD digits, 1..8; output width is 4*DIGITS.
- CLK  in  1  system clock; all state changes on its rising edge.
- CLR  in  1  reset, asynchronous, active-low; asserted when low.
- CE  in  1  count tick enable, one CLK-wide pulse per count period (e.g. 1 Hz).
- START  in  1  start or resume counting.
- STOP  in  1  pause counting.
- LOAD  in  1  write LOAD_VAL into the preset register and into Q; the timer goes idle.
- LOAD_VAL  in  4*DIGITS  packed BCD preset; digit 0 at bits [3:0].
- UP  in  1  direction: 0 counts down to zero, 1 counts up to the maximum.
- Q  out  4*DIGITS  current packed BCD count.
- RUN  out  1  high while in state RUN.
- DONE  out  1  one-cycle pulse when the terminal value is reached.

## Operation
- States: IDLE, RUN, PAUSE, END.
- Command priority within one cycle: LOAD > STOP > START > CE.
- LOAD in any state:
  - Preset and Q take LOAD_VAL.
  - State becomes IDLE.
  - Any digit above its digit maximum is clamped to that maximum.
- START:
  - From IDLE or PAUSE, go to RUN.
  - If Q already equals the terminal value, stay in the current state; no DONE.
  - From END, reload Q from the preset and go to RUN.
- STOP: from RUN, go to PAUSE. In all other states it is ignored.
- CE in RUN steps Q by one BCD step.
  - Down: the lowest digit decrements; a digit at 0 wraps to its maximum and borrows into the next digit.
  - Up: the lowest digit increments; a digit at its maximum wraps to 0 and carries into the next digit.
- CE outside RUN is ignored.
- Terminal value: all zeros when counting down; all digit maxima when counting up.
  - The tick that makes Q equal the terminal value also moves the state to END and asserts DONE for one cycle.
  - Q holds at the terminal value; it never wraps past it.
- Changing UP takes effect on the next tick. If Q already equals the new terminal value, the next CE in RUN moves to END with DONE and no Q change.
- Digit maximum is 9 for all digits (see Configuration for mm:ss).

## Timing
- Reset values (CLR low, asynchronous): Q=0, preset=0, state IDLE, RUN=0, DONE=0.
- CLR release is synchronous to CLK; the first command is accepted on the first edge with CLR high.
- Q, RUN and DONE are registered. Command or tick sampled at edge n is visible after edge n.
- DONE is high exactly one cycle, the same cycle Q first shows the terminal value.
- CLR low during RUN: immediate return to the reset values; the preset is lost.
- LOAD and CE together: LOAD wins and the tick is dropped.
- STOP and CE together in RUN: PAUSE, and Q is unchanged.
- Commands are level-sampled. Held high, they re-act every cycle with the same result, which is idempotent.

## Configuration
- TIMER_MMSS_EN defined: digits 1 and 3 have a maximum of 5, giving a mm:ss (and higher) format; e.g. 10:00 down gives 09:59.
  - Digit maxima for clamping and for the up-count terminal value follow the same rule.
  - Requires DIGITS >= 2.
- TIMER_MMSS_EN undefined: every digit has a maximum of 9, giving pure decimal.

## Structure
- Shared package timer_pkg holds:
  - State encoding constants IDLE/RUN/PAUSE/END.
  - BCD digit width constant (4).
  - A function returning the digit maximum for a given digit index, honouring TIMER_MMSS_EN.
- Sub-module bcd_digit_cnt: one BCD digit with an up/down step, a parametrised maximum, clamped load, and carry/borrow in/out. It is instantiated DIGITS times in a ripple chain.
- The top FSM holds the preset register and the terminal-value compare.

## Test plan
- Reset mid-count: RUN at Q=0x0042, pull CLR low -> Q=0, RUN=0, DONE=0 with no CLK edge needed.
- Down with borrow: LOAD 0x0100, START, 1 CE -> Q=0x0099. With TIMER_MMSS_EN, LOAD 0x1000 and 1 CE -> 0x0959.
- Terminal reached: LOAD 0x0002, START, 2 CE -> Q=0x0000, DONE high one cycle, state END. A 3rd CE leaves Q=0 with no DONE.
- Restart from END: after the previous test, START -> Q=0x0002 and RUN=1.
- Priority: in RUN at Q=0x0050, STOP and CE in the same cycle -> Q=0x0050 and PAUSE. LOAD 0x0012 together with CE -> Q=0x0012, IDLE.
- Up count and clamp: LOAD 0x9AF9 -> Q=0x9999 (mm:ss: 0x5959). START with UP=1 -> stays IDLE, no DONE. LOAD 0x9998, START, 1 CE -> Q=0x9999, DONE.
